// File: rtl/aes_round_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : aes_round_ctrl
// Brief    : Iterative AES encryption round sequencer with key fetch handshake.
// Revision : 1.0
// ============================================================================
module aes_round_ctrl #(
  parameter int NR              = 10,
  parameter bit BYPASS_MIX_LAST = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] plaintext,
  output logic         rk_req,
  output logic [3:0]   rk_round,
  input  logic         rk_valid,
  input  logic [127:0] round_key,
  output logic [127:0] dp_state,
  output logic         dp_last,
  input  logic [127:0] dp_result,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] ciphertext,
  output logic         busy
);

  localparam logic [3:0] c_nr = 4'(NR);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_KEY0  = 2'd1,
    S_ROUND = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t       r_fsm;
  state_t       w_fsm_nxt;
  logic [3:0]   r_rnd;
  logic [3:0]   w_rnd_nxt;
  logic [127:0] r_st;
  logic [127:0] w_st_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fsm <= S_IDLE;
      r_rnd <= 4'd0;
      r_st  <= '0;
    end else begin
      r_fsm <= w_fsm_nxt;
      r_rnd <= w_rnd_nxt;
      r_st  <= w_st_nxt;
    end
  end

  // Outputs depend only on registered state, never on in_valid/out_ready.
  always_comb begin
    w_fsm_nxt = r_fsm;
    w_rnd_nxt = r_rnd;
    w_st_nxt  = r_st;
    in_ready  = 1'b0;
    rk_req    = 1'b0;
    rk_round  = 4'd0;
    dp_last   = 1'b0;
    out_valid = 1'b0;
    unique case (r_fsm)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_st_nxt  = plaintext;
          w_rnd_nxt = 4'd0;
          w_fsm_nxt = S_KEY0;
        end
      end
      S_KEY0: begin
        rk_req = 1'b1;
        if (rk_valid) begin
          w_st_nxt  = r_st ^ round_key;
          w_rnd_nxt = 4'd1;
          w_fsm_nxt = S_ROUND;
        end
      end
      S_ROUND: begin
        rk_req   = 1'b1;
        rk_round = r_rnd;
        dp_last  = BYPASS_MIX_LAST && (r_rnd == c_nr);
        if (rk_valid) begin
          w_st_nxt = dp_result ^ round_key;
          // Counter saturates at NR; the final round exits instead of counting.
          if (r_rnd == c_nr) begin
            w_fsm_nxt = S_DONE;
          end else begin
            w_rnd_nxt = r_rnd + 4'd1;
          end
        end
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          w_fsm_nxt = S_IDLE;
          w_rnd_nxt = 4'd0;
        end
      end
      default: begin
        w_fsm_nxt = S_IDLE;
      end
    endcase
  end

  assign dp_state   = r_st;
  assign ciphertext = r_st;
  assign busy       = (r_fsm != S_IDLE);

endmodule
`default_nettype wire
